alu_mem_stage: RTL and testbench

- Execute/memory stage directly downstream of the control unit (CU).
- Consumes the CU's per-cycle outputs: operand1, operand2, offset, opcode, sel1, sel3, w_r.
- Produces result2, which the CU writes back into its register file.
- Contains a registered ALU, a 2^ADDR_BITS x DATA_WIDTH data memory, a result mux, and a power-on memory-clear sequencer.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/data_mem.sv | 27 ++
 rtl/alu_mem_stage.sv | 141 ++++++++++++++
 tb/tb_alu_mem_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, widths and stage FSM encoding
package cpu_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_BITS  = 5;
  localparam int INSTR_WIDTH    = 20;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - single-port RAM, synchronous write and read-before-write synchronous read
module data_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Output register sees the pre-write contents when the same word is written this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/alu_mem_stage.sv
// rtl/alu_mem_stage.sv - execute/memory stage: registered ALU, data memory, power-on clear
// Optional status flags under STATUS_FLAGS_EN.
module alu_mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  busy
`ifdef STATUS_FLAGS_EN
  ,
  output logic                  zero_flag,
  output logic                  carry_flag
`endif
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  state_t                state, state_nxt;
  logic [ADDR_BITS-1:0]  init_cnt;
  logic [DATA_WIDTH-1:0] alu_d, alu_q, mem_q;
  logic [DATA_WIDTH-1:0] eff_addr;
  logic [ADDR_BITS-1:0]  run_addr, mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  run;

  assign run      = (state == RUN);
  assign eff_addr = sel3 ? (operand1 + offset) : operand1;
  assign run_addr = eff_addr[ADDR_BITS-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // INIT owns the memory port; w_r from the CU is ignored until the clear completes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = run_addr;
    mem_wdata = operand2;
    case (state)
      INIT: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = init_cnt;
        mem_wdata = '0;
        if (init_cnt == LAST_ADDR) state_nxt = RUN;
      end
      RUN: begin
        mem_we = w_r;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    alu_d = '0;
    case (opcode)
      OP_ADD:  alu_d = operand1 + operand2;
      OP_SUB:  alu_d = operand1 - operand2;
      OP_AND:  alu_d = operand1 & operand2;
      OP_OR:   alu_d = operand1 | operand2;
      OP_XOR:  alu_d = operand1 ^ operand2;
      OP_NOT:  alu_d = ~operand1;
      OP_SHL:  alu_d = operand1 << operand2[2:0];
      OP_SHR:  alu_d = operand1 >> operand2[2:0];
      OP_ADDI: alu_d = operand1 + offset;
      default: alu_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     alu_q <= '0;
    else if (run) alu_q <= alu_d;
  end

  data_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .re    (run),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_q)
  );

  assign result2 = sel1 ? alu_q : mem_q;

`ifdef STATUS_FLAGS_EN
  logic [DATA_WIDTH:0] add_ext, sub_ext, addi_ext;
  logic                flag_upd, carry_d;

  assign add_ext  = {1'b0, operand1} + {1'b0, operand2};
  assign sub_ext  = {1'b0, operand1} - {1'b0, operand2};
  assign addi_ext = {1'b0, operand1} + {1'b0, offset};

  // The extended difference goes negative exactly when operand1 < operand2.
  always_comb begin
    flag_upd = 1'b0;
    carry_d  = 1'b0;
    case (opcode)
      OP_ADD:  begin flag_upd = sel1; carry_d = add_ext[DATA_WIDTH];  end
      OP_SUB:  begin flag_upd = sel1; carry_d = sub_ext[DATA_WIDTH];  end
      OP_ADDI: begin flag_upd = sel1; carry_d = addi_ext[DATA_WIDTH]; end
      default: begin flag_upd = 1'b0; carry_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (run && flag_upd) begin
      zero_flag  <= (alu_d == '0);
      carry_flag <= carry_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_mem_stage.sv
// tb/tb_alu_mem_stage.sv - randomized self-checking bench for alu_mem_stage against an arithmetic model
module tb_alu_mem_stage;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] operand1 = '0, operand2 = '0, offset = '0;
  logic [3:0] opcode = '0;
  logic       sel1 = 1'b0, sel3 = 1'b0, w_r = 1'b0;
  logic [7:0] result2;
  logic       busy;
`ifdef STATUS_FLAGS_EN
  logic       zero_flag, carry_flag;
`endif

  always #5 clk = ~clk;

  alu_mem_stage dut (
    .clk      (clk),
    .rst      (rst),
    .operand1 (operand1),
    .operand2 (operand2),
    .offset   (offset),
    .opcode   (opcode),
    .sel1     (sel1),
    .sel3     (sel3),
    .w_r      (w_r),
    .result2  (result2),
`ifdef STATUS_FLAGS_EN
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
`endif
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;

  int since_rst;
  int m_mem [DEPTH];
  int m_alu, m_memq, m_z, m_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int alu_ref(input int op, input int a, input int b, input int off);
    case (op)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      5:       return 255 - a;
      6:       return (a * (2 ** (b % 8))) % 256;
      7:       return a / (2 ** (b % 8));
      8:       return (a + off) % 256;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    int a, b, off, op, addr;
    a = int'(operand1); b = int'(operand2); off = int'(offset); op = int'(opcode);
    if (since_rst < DEPTH) begin
      m_mem[since_rst] = 0;
      since_rst++;
    end else begin
      addr   = (sel3 ? a + off : a) % DEPTH;
      m_memq = m_mem[addr];
      if (w_r) m_mem[addr] = b;
      m_alu = alu_ref(op, a, b, off);
      if (sel1 && (op == 0 || op == 1 || op == 8)) begin
        m_z = (m_alu == 0);
        if (op == 1)      m_c = (a < b);
        else if (op == 0) m_c = (a + b > 255);
        else              m_c = (a + off > 255);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", busy, since_rst < DEPTH);
    chk("result2", result2, sel1 ? m_alu : m_memq);
`ifdef STATUS_FLAGS_EN
    chk("zero_flag", zero_flag, m_z);
    chk("carry_flag", carry_flag, m_c);
`endif
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] off, input logic s1, input logic s3, input logic wr);
    opcode = op; operand1 = a; operand2 = b; offset = off; sel1 = s1; sel3 = s3; w_r = wr;
  endtask

  task automatic drive_random();
    drive(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
    if ($urandom_range(0, 1) == 0) operand1 = 8'($urandom_range(0, 7));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    since_rst = 0; m_alu = 0; m_memq = 0; m_z = 0; m_c = 0;
    chk("rst_result2", result2, 0);
    chk("rst_busy", busy, 1);
`ifdef STATUS_FLAGS_EN
    chk("rst_zero", zero_flag, 0);
    chk("rst_carry", carry_flag, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Runs the clear phase with the given store attempt held on the bus and checks its length.
  task automatic clear_phase(input logic [7:0] wdata, input logic force_addr7);
    int n = 0;
    while (busy && n < 40) begin
      drive_random();
      w_r = 1'b1;
      operand2 = wdata;
      if (force_addr7) begin operand1 = 8'h07; sel3 = 1'b0; end
      step();
      n++;
    end
    chk("busy_cycles", n, DEPTH);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    #1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    clear_phase(8'h99, 1'b0);

    for (int a = 0; a < DEPTH; a++) begin
      drive(4'($urandom_range(0, 15)), 8'(a), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
      step();
      chk("cleared", result2, 0);
    end

    drive(4'b0000, 8'd3, 8'd2, 8'd0, 1'b1, 1'b0, 1'b0); step();
    chk("add_3_2", result2, 8'h05);
`ifdef STATUS_FLAGS_EN
    chk("add_zero", zero_flag, 0); chk("add_carry", carry_flag, 0);
`endif
    drive(4'b0001, 8'd2, 8'd3, 8'd0, 1'b1, 1'b0, 1'b0); step();
    chk("sub_2_3", result2, 8'hFF);
`ifdef STATUS_FLAGS_EN
    chk("sub_borrow", carry_flag, 1);
`endif
    drive(4'b0000, 8'h80, 8'h80, 8'd0, 1'b1, 1'b0, 1'b0); step();
    chk("add_80_80", result2, 8'h00);
`ifdef STATUS_FLAGS_EN
    chk("add80_zero", zero_flag, 1); chk("add80_carry", carry_flag, 1);
`endif

    repeat (3) begin drive(4'b1111, 8'd1, 8'hAA, 8'd4, 1'b0, 1'b1, 1'b1); step(); end
    drive(4'b1111, 8'd1, 8'h00, 8'd4, 1'b0, 1'b1, 1'b0); step();
    chk("store_aa", result2, 8'hAA);
    drive(4'b1111, 8'd4, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0); step();
    chk("addr4_clear", result2, 8'h00);

    drive(4'b1111, 8'h1F, 8'h5C, 8'h03, 1'b0, 1'b1, 1'b1); step();
    drive(4'b1111, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); step();
    chk("wrap_5c", result2, 8'h5C);

    drive(4'b1111, 8'd9, 8'h33, 8'd0, 1'b0, 1'b0, 1'b1); step();
    drive(4'b1111, 8'd9, 8'h44, 8'd0, 1'b0, 1'b0, 1'b1); step();
    chk("rbw_old", result2, 8'h33);
    drive(4'b1111, 8'd9, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0); step();
    chk("rbw_new", result2, 8'h44);

    drive(4'b1111, 8'd7, 8'h77, 8'd0, 1'b0, 1'b0, 1'b1); step();
    drive(4'b1111, 8'd7, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0); step();
    chk("store_77", result2, 8'h77);
    do_reset();
    clear_phase(8'h11, 1'b1);
    drive(4'b1111, 8'd7, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0); step();
    chk("addr7_recleared", result2, 8'h00);

    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
